heater_thermostat_ctrl: RTL



---
 rtl/heater_thermostat_ctrl.sv | 144 ++++++++++++++
 1 files changed

// File: rtl/heater_thermostat_ctrl.sv
// Water-heater relay controller: hysteresis regulation with min on/off dwell, over-temp trip and stale-sample watchdog.
// Optional dry-fire (continuous-on) limit is compiled in when HEATER_MAX_ON_EN is defined.
module heater_thermostat_ctrl #(
  parameter logic [31:0]        MIN_ON_CYCLES  = 32'd27_000_000,
  parameter logic [31:0]        MIN_OFF_CYCLES = 32'd27_000_000,
  parameter logic [31:0]        STALE_CYCLES   = 32'd81_000_000,
  parameter logic signed [15:0] HYST           = 16'sd16,
  parameter logic signed [15:0] TEMP_HI        = 16'sd1440,
  parameter logic signed [15:0] TEMP_LO        = 16'sd0,
  parameter logic [31:0]        MAX_ON_CYCLES  = 32'd270_000_000
) (
  input  logic        CLK,
  input  logic        RST_N,
  input  logic        ENABLE,
  input  logic        TEMP_VALID,
  input  logic [15:0] TEMPERATURE,
  input  logic [15:0] SETPOINT,
  output logic        HEATER_ON,
  output logic        FAULT,
  output logic [2:0]  STATE
);

  localparam int unsigned CNT_W  = 32;
  localparam int unsigned TEMP_W = 16;
  localparam int unsigned CMP_W  = 17;
  localparam int unsigned ST_W   = 3;
  localparam logic [CNT_W-1:0]  CNT_MAX       = '1;
  localparam logic [TEMP_W-1:0] POWER_ON_TEMP = 16'h0550;

  typedef enum logic [ST_W-1:0] {
    S_DISABLED = 3'd0,
    S_ACQUIRE  = 3'd1,
    S_OFF      = 3'd2,
    S_ON       = 3'd3,
    S_FAULT    = 3'd4
  } state_e;

  state_e                    state_q, state_d;
  logic [CNT_W-1:0]          stale_q, stale_d;
  logic [CNT_W-1:0]          dwell_q, dwell_d;
  logic signed [TEMP_W-1:0]  temp_q, temp_d;
  logic                      heater_q, fault_q;
  logic                      active, accept, out_of_range, stale_hit, dry_fire, trip;
  logic signed [CMP_W-1:0]   temp_x, setpoint_x, low_thr;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == CNT_MAX) ? v : v + CNT_W'(1);
  endfunction

  // Sample qualification; the sensor's power-on reading is dropped while acquiring
  assign active       = (state_q == S_ACQUIRE) || (state_q == S_OFF) || (state_q == S_ON);
  assign accept       = TEMP_VALID && ENABLE && active &&
                        !((state_q == S_ACQUIRE) && (TEMPERATURE == POWER_ON_TEMP));
  assign out_of_range = ($signed(TEMPERATURE) > TEMP_HI) || ($signed(TEMPERATURE) < TEMP_LO);
  assign stale_hit    = stale_q >= STALE_CYCLES;

  // One extra bit keeps SETPOINT - HYST from wrapping at very low setpoints
  assign temp_x     = {temp_q[TEMP_W-1], temp_q};
  assign setpoint_x = {SETPOINT[TEMP_W-1], SETPOINT};
  assign low_thr    = setpoint_x - {HYST[TEMP_W-1], HYST};

`ifdef HEATER_MAX_ON_EN
  logic [CNT_W-1:0] on_q, on_d;

  assign on_d     = (state_q == S_ON) ? sat_inc(on_q) : '0;
  assign dry_fire = (state_q == S_ON) && (on_q >= MAX_ON_CYCLES);

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) on_q <= '0;
    else        on_q <= on_d;
  end
`else
  logic unused_max_on;

  assign unused_max_on = ^MAX_ON_CYCLES;
  assign dry_fire      = 1'b0;
`endif

  assign trip = (accept && out_of_range) || stale_hit || dry_fire;

  // Next-state: ENABLE low wins, then fault conditions, then regulation
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_DISABLED: begin
        if (ENABLE) state_d = S_ACQUIRE;
      end
      S_ACQUIRE: begin
        if (!ENABLE)     state_d = S_DISABLED;
        else if (trip)   state_d = S_FAULT;
        else if (accept) state_d = S_OFF;
      end
      S_OFF: begin
        if (!ENABLE)    state_d = S_DISABLED;
        else if (trip)  state_d = S_FAULT;
        else if ((dwell_q >= MIN_OFF_CYCLES) && (temp_x < low_thr)) state_d = S_ON;
      end
      S_ON: begin
        if (!ENABLE)    state_d = S_DISABLED;
        else if (trip)  state_d = S_FAULT;
        else if ((dwell_q >= MIN_ON_CYCLES) && (temp_x >= setpoint_x)) state_d = S_OFF;
      end
      S_FAULT: begin
        if (!ENABLE) state_d = S_DISABLED;
      end
      default: state_d = S_DISABLED;
    endcase
  end

  // Datapath: sample latch, stale watchdog, dwell timer
  always_comb begin
    temp_d  = temp_q;
    stale_d = '0;
    dwell_d = sat_inc(dwell_q);
    if (accept) temp_d = TEMPERATURE;
    if (active && !accept) stale_d = sat_inc(stale_q);
    if (state_d != state_q) begin
      dwell_d = ((state_q == S_ACQUIRE) && (state_d == S_OFF)) ? MIN_OFF_CYCLES : '0;
    end
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q  <= S_DISABLED;
      stale_q  <= '0;
      dwell_q  <= '0;
      temp_q   <= '0;
      heater_q <= 1'b0;
      fault_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      stale_q  <= stale_d;
      dwell_q  <= dwell_d;
      temp_q   <= temp_d;
      heater_q <= (state_d == S_ON);
      fault_q  <= (state_d == S_FAULT);
    end
  end

  assign HEATER_ON = heater_q;
  assign FAULT     = fault_q;
  assign STATE     = state_q;

endmodule
